instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Produces the instruction stream consumed by the main control decoder: holds PC, fetches 32-bit words from instruction memory over a req/ack handshake, and presents the instruction plus decoded OpCode/Funct fields to decode over a valid/ready handshake.
- Resolves the next PC from the decoder's Jump/Branch outputs and the ALU Zero flag, sampled at instruction accept.
- Sits between instruction memory and the control/datapath front end.

Parameters:
- RESET_PC, 32'h00000000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ImemReq  out  1  fetch request to instruction memory
- ImemAddr  out  32  fetch address; word aligned
- ImemRdata  in  32  fetched word, valid when ImemAck=1
- ImemAck  in  1  memory response strobe, 1 cycle
- InstrValid  out  1  Instr/OpCode/Funct/PC valid to decode
- InstrReady  in  1  decode accepts the held instruction
- Instr  out  32  held instruction register (IR)
- OpCode  out  6  IR[31:26]
- Funct  out  6  IR[5:0]
- PC  out  32  address of the held instruction
- PCPlus4  out  32  PC+4, modulo 2^32
- Jump  in  1  from control; sampled only at accept
- Branch  in  1  from control; sampled only at accept
- Zero  in  1  from ALU; sampled only at accept

Behaviour:
- States: IDLE, FETCH, HOLD.
- Reset (rst_n=0, asynchronous): state=IDLE, PC=RESET_PC, IR=0, ImemReq=0, InstrValid=0. OpCode, Funct and PCPlus4 follow IR and PC combinationally (PCPlus4=RESET_PC+4).
- IDLE: lasts exactly one cycle, then FETCH. ImemAck in IDLE is ignored, which discards a response left over from a fetch interrupted by reset.
- FETCH:
  - ImemReq=1 and ImemAddr=PC. Both are held stable until ImemAck, with unbounded wait.
  - On ImemAck: IR<=ImemRdata and state goes to HOLD.
  - Minimum fetch latency is 1 cycle: an ack in the same cycle as the request is legal.
- HOLD:
  - InstrValid=1, ImemReq=0. IR and PC are held stable until InstrReady=1.
  - Accept is InstrValid & InstrReady. At accept, PC is loaded with the next PC and state goes to FETCH.
  - This gives one request bubble per instruction: throughput is 1 instruction per (ack latency + 1) cycles, minimum 2.
- Next-PC priority, evaluated at accept:
  - Jump=1: {PCPlus4[31:28], IR[25:0], 2'b00}.
  - Else Branch & Zero: PCPlus4 + {{14{IR[15]}}, IR[15:0], 2'b00}, modulo 2^32.
  - Else: PCPlus4.
- Jump and Branch both 1: Jump wins.
- Branch=1, Zero=0: sequential (PCPlus4).
- Jump/Branch/Zero toggling outside accept: no effect.
- Wrap-around: PC=32'hFFFFFFFC gives PCPlus4=0. A negative branch offset below 0 wraps modulo 2^32. No exception is raised.
- ImemAck while in HOLD: ignored, IR unchanged.
- Reset asserted mid-FETCH or mid-HOLD: immediate return to reset values. The pending request is dropped and the held instruction is lost.
- ImemAddr[1:0] and PC[1:0] are always 0.

Test Plan:
- Reset release, memory acks every request 1 cycle later with word 0x00000000 → ImemReq rises 1 cycle after rst_n deasserts. ImemAddr sequence is 0x0, 0x4, 0x8. InstrValid=1 with OpCode=0, Funct=0. InstrReady held 1 → one instruction every 2 cycles.
- IR=0x08000010 (j), accept with Jump=1, PC=0x00000040 → next ImemAddr=0x00000040. Same IR at PC=0xF0000000 → next ImemAddr=0xF0000040.
- IR=0x1000FFFE (beq, offset -2), PC=0x100:
  - accept with Branch=1, Zero=1 → next ImemAddr=0x000000FC.
  - accept with Branch=1, Zero=0 → 0x00000104.
  - accept with Jump=1, Branch=1, Zero=1 → jump target wins.
- Backpressure: InstrReady=0 for 5 cycles, Jump toggled and a stray ImemAck pulsed → Instr, PC and InstrValid unchanged, ImemReq=0. Release InstrReady with Jump=0, Branch=0 → PC+4 fetched.
- Slow memory: ImemAck delayed 7 cycles → ImemReq and ImemAddr stable all 7 cycles. Assert rst_n=0 mid-wait, then ack 1 cycle after release → ack ignored, refetch from RESET_PC.
- PC=0xFFFFFFFC, sequential accept → PCPlus4=0 and next ImemAddr=0x00000000.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch front end. Holds the PC, fetches one 32-bit word at a time
// from instruction memory over a req/ack handshake, and presents the word plus
// its OpCode/Funct fields to the decoder over a valid/ready handshake. The
// next PC is chosen from Jump/Branch/Zero sampled when decode accepts.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   ImemReq/ImemAddr    fetch request and word-aligned address (out)
//   ImemRdata/ImemAck   fetched word and its one-cycle response strobe (in)
//   InstrValid          Instr/OpCode/Funct/PC valid to decode (out)
//   InstrReady          decode accepts the held instruction (in)
//   Instr               held instruction register (out)
//   OpCode, Funct       Instr[31:26], Instr[5:0] (out)
//   PC, PCPlus4         address of held instruction and PC+4 (out)
//   Jump, Branch, Zero  control-flow inputs, sampled only at accept (in)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        ImemReq,
   output logic [31:0] ImemAddr,
   input  logic [31:0] ImemRdata,
   input  logic        ImemAck,
   output logic        InstrValid,
   input  logic        InstrReady,
   output logic [31:0] Instr,
   output logic [5:0]  OpCode,
   output logic [5:0]  Funct,
   output logic [31:0] PC,
   output logic [31:0] PCPlus4,
   input  logic        Jump,
   input  logic        Branch,
   input  logic        Zero
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   // Low address bits are forced to zero so a misaligned RESET_PC can never
   // produce a misaligned fetch.
   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;

   logic [31:0] pc_plus4;
   logic [31:0] jump_target;
   logic [31:0] branch_target;
   logic [31:0] next_pc;
   logic        accept;

   // Sequential PC wraps naturally modulo 2^32.
   assign pc_plus4      = pc_q + 32'd4;
   assign jump_target   = {pc_plus4[31:28], ir_q[25:0], 2'b00};
   assign branch_target = pc_plus4 + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

   assign accept = (state_q == HOLD) && InstrReady;

   // Jump has priority over a taken branch; an untaken branch is sequential.
   always_comb begin
      next_pc = pc_plus4;
      if (Jump) begin
         next_pc = jump_target;
      end else if (Branch && Zero) begin
         next_pc = branch_target;
      end
   end

   // NOTE: every signal written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      case (state_q)
         // One dead cycle after reset; any ack still in flight from a fetch
         // cut short by reset lands here and is dropped.
         IDLE: state_d = FETCH;
         FETCH: begin
            if (ImemAck) begin
               ir_d    = ImemRdata;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (accept) begin
               pc_d    = {next_pc[31:2], 2'b00};
               state_d = FETCH;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC_ALIGNED;
         ir_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   assign ImemReq    = (state_q == FETCH);
   assign ImemAddr   = pc_q;
   assign InstrValid = (state_q == HOLD);
   assign Instr      = ir_q;
   assign OpCode     = ir_q[31:26];
   assign Funct      = ir_q[5:0];
   assign PC         = pc_q;
   assign PCPlus4    = pc_plus4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit. Inputs change and outputs are sampled
// on the falling clock edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        ImemReq;
   logic [31:0] ImemAddr;
   logic [31:0] ImemRdata;
   logic        ImemAck;
   logic        InstrValid;
   logic        InstrReady;
   logic [31:0] Instr;
   logic [5:0]  OpCode;
   logic [5:0]  Funct;
   logic [31:0] PC;
   logic [31:0] PCPlus4;
   logic        Jump;
   logic        Branch;
   logic        Zero;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ImemReq    (ImemReq),
      .ImemAddr   (ImemAddr),
      .ImemRdata  (ImemRdata),
      .ImemAck    (ImemAck),
      .InstrValid (InstrValid),
      .InstrReady (InstrReady),
      .Instr      (Instr),
      .OpCode     (OpCode),
      .Funct      (Funct),
      .PC         (PC),
      .PCPlus4    (PCPlus4),
      .Jump       (Jump),
      .Branch     (Branch),
      .Zero       (Zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Bounded wait for a fetch request.
   task automatic wait_req();
      int n = 0;
      while (!ImemReq && n < 20) begin
         tick();
         n++;
      end
      if (!ImemReq) check("req_timeout", {31'd0, ImemReq}, 32'd1);
   endtask

   // Serve one fetch: expect addr, wait lat cycles (checking the request stays
   // put), then ack with data and confirm the instruction is presented.
   task automatic do_fetch(input string tag, input logic [31:0] addr,
                           input logic [31:0] data, input int lat);
      wait_req();
      check({tag, "_addr"}, ImemAddr, addr);
      for (int i = 0; i < lat; i++) begin
         Jump = ~Jump;
         tick();
         check({tag, "_wait_req"}, {31'd0, ImemReq}, 32'd1);
         check({tag, "_wait_addr"}, ImemAddr, addr);
      end
      Jump      = 1'b0;
      ImemAck   = 1'b1;
      ImemRdata = data;
      tick();
      ImemAck   = 1'b0;
      ImemRdata = 32'hDEAD_BEEF;
      check({tag, "_valid"}, {31'd0, InstrValid}, 32'd1);
      check({tag, "_instr"}, Instr, data);
      check({tag, "_pc"}, PC, addr);
      check({tag, "_req_low"}, {31'd0, ImemReq}, 32'd0);
   endtask

   task automatic accept(input logic j, input logic b, input logic z);
      InstrReady = 1'b1;
      Jump       = j;
      Branch     = b;
      Zero       = z;
      tick();
      InstrReady = 1'b0;
      Jump       = 1'b0;
      Branch     = 1'b0;
      Zero       = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int t0;
      int t1;
      rst_n      = 1'b0;
      ImemRdata  = 32'd0;
      ImemAck    = 1'b0;
      InstrReady = 1'b0;
      Jump       = 1'b0;
      Branch     = 1'b0;
      Zero       = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst_req", {31'd0, ImemReq}, 32'd0);
      check("rst_valid", {31'd0, InstrValid}, 32'd0);
      check("rst_pc", PC, 32'h0);
      check("rst_pcplus4", PCPlus4, 32'h4);
      check("rst_instr", Instr, 32'h0);

      // Release: request appears one cycle later
      rst_n = 1'b1;
      tick();
      check("rel_req", {31'd0, ImemReq}, 32'd1);
      check("rel_addr", ImemAddr, 32'h0);

      // Sequential stream of zero words, ready held
      do_fetch("seq0", 32'h0, 32'h0, 0);
      check("seq0_opcode", {26'd0, OpCode}, 32'd0);
      check("seq0_funct", {26'd0, Funct}, 32'd0);
      accept(1'b0, 1'b0, 1'b0);
      wait_req();
      t0 = cyc;
      do_fetch("seq4", 32'h4, 32'h0, 0);
      accept(1'b0, 1'b0, 1'b0);
      t1 = cyc;
      check("throughput", t1 - t0, 32'd2);
      check("seq8_req", {31'd0, ImemReq}, 32'd1);

      // Jump to 0x40
      do_fetch("j40", 32'h8, 32'h0800_0010, 0);
      accept(1'b1, 1'b0, 1'b0);
      // beq at 0x40 back to 0xFFFFFFF8 (0x44 - 0x4C wraps below zero)
      do_fetch("bwrap", 32'h40, 32'h1000_FFED, 0);
      accept(1'b0, 1'b1, 1'b1);
      // j 0 at 0xFFFFFFF8 keeps PCPlus4[31:28]=F
      do_fetch("jhi", 32'hFFFF_FFF8, 32'h0800_0000, 0);
      accept(1'b1, 1'b0, 1'b0);
      do_fetch("jF0", 32'hF000_0000, 32'h0800_0010, 0);
      accept(1'b1, 1'b0, 1'b0);
      // j to 0xFFFFFFFC, then sequential wrap to 0
      do_fetch("jtop", 32'hF000_0040, 32'h0BFF_FFFF, 0);
      accept(1'b1, 1'b0, 1'b0);
      do_fetch("wrap", 32'hFFFF_FFFC, 32'h0000_0000, 0);
      check("wrap_pcplus4", PCPlus4, 32'h0);
      accept(1'b0, 1'b0, 1'b0);
      // j to 0x100
      do_fetch("j100", 32'h0, 32'h0800_0040, 0);
      accept(1'b1, 1'b0, 1'b0);

      // beq -2 at 0x100: taken -> 0xFC
      do_fetch("beq_t", 32'h100, 32'h1000_FFFE, 0);
      accept(1'b0, 1'b1, 1'b1);
      do_fetch("fc", 32'hFC, 32'h0000_0000, 0);
      accept(1'b0, 1'b0, 1'b0);
      // not taken -> 0x104
      do_fetch("beq_nt", 32'h100, 32'h1000_FFFE, 0);
      accept(1'b0, 1'b1, 1'b0);
      // Jump and taken branch together: jump target 0x0003FFF8 wins
      do_fetch("jb", 32'h104, 32'h1000_FFFE, 0);
      accept(1'b1, 1'b1, 1'b1);

      // Backpressure with control toggling and a stray ack
      do_fetch("bp", 32'h0003_FFF8, 32'h2402_ABCD, 0);
      for (int i = 0; i < 5; i++) begin
         Jump   = i[0];
         Branch = 1'b1;
         Zero   = 1'b1;
         if (i == 2) begin
            ImemAck   = 1'b1;
            ImemRdata = 32'h1234_5678;
         end
         tick();
         ImemAck = 1'b0;
         check("bp_instr", Instr, 32'h2402_ABCD);
         check("bp_pc", PC, 32'h0003_FFF8);
         check("bp_valid", {31'd0, InstrValid}, 32'd1);
         check("bp_req", {31'd0, ImemReq}, 32'd0);
      end
      Jump   = 1'b0;
      Branch = 1'b0;
      Zero   = 1'b0;
      check("bp_opcode", {26'd0, OpCode}, 32'h09);
      check("bp_funct", {26'd0, Funct}, 32'h0D);
      accept(1'b0, 1'b0, 1'b0);

      // Slow memory: 7-cycle ack latency
      do_fetch("slow", 32'h0003_FFFC, 32'h0000_0000, 7);
      accept(1'b0, 1'b0, 1'b0);

      // Reset in the middle of a pending fetch
      wait_req();
      check("mid_addr", ImemAddr, 32'h0004_0000);
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      check("mid_rst_req", {31'd0, ImemReq}, 32'd0);
      check("mid_rst_pc", PC, 32'h0);
      check("mid_rst_valid", {31'd0, InstrValid}, 32'd0);
      tick();
      rst_n     = 1'b1;
      ImemAck   = 1'b1;
      ImemRdata = 32'hCAFE_F00D;
      tick();
      ImemAck = 1'b0;
      check("late_ack_valid", {31'd0, InstrValid}, 32'd0);
      check("late_ack_instr", Instr, 32'h0);
      check("refetch_req", {31'd0, ImemReq}, 32'd1);
      do_fetch("refetch", 32'h0, 32'h0000_0020, 0);
      check("refetch_funct", {26'd0, Funct}, 32'h20);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
